pipeline_sequencer: RTL and testbench
=====================================

PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have: CLK  in  1  clock; all state updates on the rising edge.
REQ-002 SHALL have: nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: ihit  in  1  instruction fetch completed this cycle.
REQ-004 SHALL have: dhit  in  1  data access completed this cycle.
REQ-005 SHALL have: dREN_m, dWEN_m  in  1 each  MEM-stage instruction requests a data read or write.
REQ-006 SHALL have: halt_m  in  1  MEM-stage instruction is HALT.
REQ-007 SHALL have: brtaken_ex  in  1  taken branch or jump resolved in EX.
REQ-008 SHALL have: ld_ex  in  1  EX-stage instruction is a load.
REQ-009 SHALL have: wsel_ex  in  5  EX-stage destination register.
REQ-010 SHALL have: rs_id, rt_id  in  5 each  ID-stage source registers.
REQ-011 SHALL have: pc_en  out  1  PC update enable.
REQ-012 SHALL have: ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush  out  1 each  latch controls; flush takes priority over enable inside each latch.
REQ-013 SHALL have: halted  out  1  pipeline drained after HALT.
REQ-014 SHALL have: stall_cnt  out  16  count of cycles with pc_en=0 while not halted.

Function
REQ-015 SHALL implement FSM states RUN, DWAIT, DRAIN, HALTED.
REQ-016 Default (RUN, no event): all *_en=1, all *_flush=0, pc_en=1.
REQ-017 Priority per cycle, highest first: halt_m, data stall, brtaken_ex, load-use, !ihit.
REQ-018 halt_m=1 in RUN or DWAIT: pc_en=0; ifid_flush, idex_flush and exmem_flush=1; memwb_en=1; next state DRAIN.
REQ-019 DRAIN lasts exactly 1 cycle: all en=0, memwb_flush=1; next state HALTED.
REQ-020 HALTED: all en=0, all flush=0, halted=1; HALTED is left only by reset.
REQ-021 Data stall: (dREN_m|dWEN_m) & !dhit in RUN -> pc_en, ifid_en, idex_en and exmem_en=0; memwb_flush=1; next state DWAIT.
REQ-022 DWAIT with !dhit: same outputs as REQ-021; remain in DWAIT.
REQ-023 DWAIT with dhit: REQ-016 outputs, subject to lower-priority rules; next state RUN.
REQ-024 RUN with (dREN_m|dWEN_m) & dhit in the same cycle: no stall; remain in RUN.
REQ-025 brtaken_ex: pc_en=1 and ifid_flush=idex_flush=1 regardless of ihit; load-use is suppressed in that cycle.
REQ-026 Load-use: ld_ex & wsel_ex!=0 & (wsel_ex==rs_id | wsel_ex==rt_id) -> pc_en=0, ifid_en=0, idex_flush=1; all other stages advance.
REQ-027 !ihit with no higher-priority event: pc_en=0 and ifid_flush=1; later stages advance.
REQ-028 stall_cnt SHALL increment by 1 on each edge where pc_en=0 and the state is RUN or DWAIT, saturating at 16'hFFFF with no wrap.
REQ-029 Outputs other than halted and stall_cnt SHALL be combinational from the current state and inputs; halted and stall_cnt SHALL be registered.

Reset
REQ-030 nRST low SHALL force state RUN, halted=0 and stall_cnt=0 immediately, including mid-DWAIT or mid-DRAIN.
REQ-031 During reset, outputs SHALL follow the RUN rules (REQ-016 to REQ-027).

Structure
REQ-032 State enum pipe_state_t and regbits_t (5-bit) SHALL reside in the shared cpu_types_pkg.
REQ-033 Load-use comparison SHALL be one combinational sub-module, load_use_detect, with inputs ld_ex, wsel_ex, rs_id, rt_id and output luhaz.

Verification
REQ-034 Reset, then ihit=1 with no events for 5 cycles -> all en=1, flush=0, stall_cnt=0.
REQ-035 dREN_m=1 with dhit=0 for 3 cycles, then dhit=1 -> DWAIT for 3 cycles with memwb_flush=1, stall_cnt=3, RUN on the next edge.
REQ-036 ld_ex=1, wsel_ex=8, rt_id=8 -> pc_en=0, ifid_en=0, idex_flush=1; the same stimulus with wsel_ex=0 -> no stall.
REQ-037 brtaken_ex=1 together with a load-use hazard and ihit=0 -> pc_en=1, ifid_flush=idex_flush=1, stall_cnt unchanged.
REQ-038 halt_m=1 during DWAIT -> DRAIN for one cycle, then halted=1, which remains set while ihit and dhit toggle; nRST pulse clears it.
REQ-039 Force 65540 consecutive !ihit cycles -> stall_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline sequencer state and the
// per-latch enable/flush control pair used by the sequencer.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

  // One pipeline latch control. Inside a latch, flush wins over en.
  typedef struct packed {
    logic en;
    logic flush;
  } latch_ctrl_t;

  localparam latch_ctrl_t LATCH_RUN = '{en: 1'b1, flush: 1'b0};
  localparam latch_ctrl_t LATCH_OFF = '{en: 1'b0, flush: 1'b0};

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detect: the EX-stage load writes a register that the
// ID-stage instruction reads. Register 0 never carries a hazard.
// Ports:
//   ld_ex   - EX instruction is a load
//   wsel_ex - EX destination register
//   rs_id   - ID source register rs
//   rt_id   - ID source register rt
//   luhaz   - hazard present
import cpu_types_pkg::*;

module load_use_detect (
  input  logic     ld_ex,
  input  regbits_t wsel_ex,
  input  regbits_t rs_id,
  input  regbits_t rt_id,
  output logic     luhaz
);

  assign luhaz = ld_ex && (wsel_ex != '0) &&
                 ((wsel_ex == rs_id) || (wsel_ex == rt_id));

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: PC / latch enable and flush control for a 5-stage
// pipeline, plus HALT drain and a saturating stall-cycle counter.
// Ports:
//   CLK, nRST              - clock, async active-low reset
//   ihit, dhit             - fetch / data access completed this cycle
//   dREN_m, dWEN_m, halt_m - MEM-stage read / write request, HALT
//   brtaken_ex, ld_ex      - EX taken branch, EX load
//   wsel_ex, rs_id, rt_id  - register indices for load-use detect
//   pc_en, *_en, *_flush   - combinational pipeline controls
//   halted, stall_cnt      - registered status
import cpu_types_pkg::*;

module pipeline_sequencer (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dREN_m,
  input  logic        dWEN_m,
  input  logic        halt_m,
  input  logic        brtaken_ex,
  input  logic        ld_ex,
  input  regbits_t    wsel_ex,
  input  regbits_t    rs_id,
  input  regbits_t    rt_id,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_flush,
  output logic        exmem_en,
  output logic        exmem_flush,
  output logic        memwb_en,
  output logic        memwb_flush,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  pipe_state_t            r_state;
  logic                   r_halted;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  pipe_state_t w_next;
  logic        w_pc_en;
  logic        w_dstall;
  logic        w_luhaz;
  latch_ctrl_t w_ifid, w_idex, w_exmem, w_memwb;

  load_use_detect u_lud (
    .ld_ex   (ld_ex),
    .wsel_ex (wsel_ex),
    .rs_id   (rs_id),
    .rt_id   (rt_id),
    .luhaz   (w_luhaz)
  );

  always_comb begin
    w_next   = r_state;
    w_pc_en  = 1'b1;
    w_dstall = 1'b0;
    w_ifid   = LATCH_RUN;
    w_idex   = LATCH_RUN;
    w_exmem  = LATCH_RUN;
    w_memwb  = LATCH_RUN;
    case (r_state)
      HALTED: begin
        w_pc_en = 1'b0;
        w_ifid  = LATCH_OFF;
        w_idex  = LATCH_OFF;
        w_exmem = LATCH_OFF;
        w_memwb = LATCH_OFF;
      end
      DRAIN: begin
        // Last instruction already retired into WB; squash the WB latch.
        w_pc_en       = 1'b0;
        w_ifid        = LATCH_OFF;
        w_idex        = LATCH_OFF;
        w_exmem       = LATCH_OFF;
        w_memwb       = LATCH_OFF;
        w_memwb.flush = 1'b1;
        w_next        = HALTED;
      end
      default: begin // RUN, DWAIT
        // In DWAIT the access is still outstanding until dhit arrives.
        w_dstall = (r_state == DWAIT) ? !dhit : ((dREN_m || dWEN_m) && !dhit);
        if (halt_m) begin
          w_pc_en       = 1'b0;
          w_ifid.flush  = 1'b1;
          w_idex.flush  = 1'b1;
          w_exmem.flush = 1'b1;
          w_next        = DRAIN;
        end else if (w_dstall) begin
          // Freeze up to MEM, insert a bubble into WB.
          w_pc_en       = 1'b0;
          w_ifid.en     = 1'b0;
          w_idex.en     = 1'b0;
          w_exmem.en    = 1'b0;
          w_memwb.flush = 1'b1;
          w_next        = DWAIT;
        end else begin
          w_next = RUN;
          if (brtaken_ex) begin
            // Redirect wins over a pending fetch and over load-use.
            w_ifid.flush = 1'b1;
            w_idex.flush = 1'b1;
          end else if (w_luhaz) begin
            w_pc_en      = 1'b0;
            w_ifid.en    = 1'b0;
            w_idex.flush = 1'b1;
          end else if (!ihit) begin
            w_pc_en      = 1'b0;
            w_ifid.flush = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state  <= w_next;
      r_halted <= (w_next == HALTED);
      if (!w_pc_en && (r_state == RUN || r_state == DWAIT) && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign pc_en       = w_pc_en;
  assign ifid_en     = w_ifid.en;
  assign ifid_flush  = w_ifid.flush;
  assign idex_en     = w_idex.en;
  assign idex_flush  = w_idex.flush;
  assign exmem_en    = w_exmem.en;
  assign exmem_flush = w_exmem.flush;
  assign memwb_en    = w_memwb.en;
  assign memwb_flush = w_memwb.flush;
  assign halted      = r_halted;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: reset-state vectors, directed corner
// sequences and randomized traffic against an outcome-level model.
module tb_pipeline_sequencer;

  typedef struct packed {
    logic       ihit, dhit, dren, dwen, halt, br, ld;
    logic [4:0] wsel, rs, rt;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [8:0] exp;
  } vec_t;

  // Output pattern order: pc, ifid en/fl, idex en/fl, exmem en/fl, memwb en/fl
  localparam logic [8:0] O_DEF   = 9'b110101010;
  localparam logic [8:0] O_HALT  = 9'b011111110;
  localparam logic [8:0] O_DSTL  = 9'b000000011;
  localparam logic [8:0] O_BR    = 9'b111111010;
  localparam logic [8:0] O_LU    = 9'b000111010;
  localparam logic [8:0] O_IMISS = 9'b011101010;
  localparam logic [8:0] O_DRAIN = 9'b000000001;
  localparam logic [8:0] O_HLTD  = 9'b000000000;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic ihit, dhit, dREN_m, dWEN_m, halt_m, brtaken_ex, ld_ex;
  logic [4:0] wsel_ex, rs_id, rt_id;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_flush, halted;
  logic [15:0] stall_cnt;
  logic [8:0] outs;

  int vectors = 0;
  int miscompares = 0;

  // Model state: outstanding data access, drain cycle pending, halted, count
  bit m_wait, m_drain, m_halt;
  int m_cnt;

  always #5 CLK = ~CLK;

  pipeline_sequencer dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN_m(dREN_m),
    .dWEN_m(dWEN_m), .halt_m(halt_m), .brtaken_ex(brtaken_ex), .ld_ex(ld_ex),
    .wsel_ex(wsel_ex), .rs_id(rs_id), .rt_id(rt_id), .pc_en(pc_en),
    .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .memwb_flush(memwb_flush), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  assign outs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, exmem_flush, memwb_en, memwb_flush};

  function automatic in_t mk(bit ih, bit dh, bit dr, bit dw, bit h, bit b, bit l,
                             int ws, int r1, int r2);
    in_t x;
    x.ihit = ih; x.dhit = dh; x.dren = dr; x.dwen = dw; x.halt = h;
    x.br = b; x.ld = l; x.wsel = 5'(ws); x.rs = 5'(r1); x.rt = 5'(r2);
    return x;
  endfunction

  function automatic in_t rnd();
    in_t x;
    x.ihit = ($urandom_range(0, 3) != 0);
    x.dhit = ($urandom_range(0, 1) != 0);
    x.dren = ($urandom_range(0, 3) == 0);
    x.dwen = ($urandom_range(0, 5) == 0);
    x.halt = ($urandom_range(0, 79) == 0);
    x.br   = ($urandom_range(0, 5) == 0);
    x.ld   = ($urandom_range(0, 2) == 0);
    x.wsel = 5'($urandom_range(0, 3));
    x.rs   = 5'($urandom_range(0, 3));
    x.rt   = 5'($urandom_range(0, 3));
    return x;
  endfunction

  task automatic drive(input in_t x);
    ihit = x.ihit; dhit = x.dhit; dREN_m = x.dren; dWEN_m = x.dwen;
    halt_m = x.halt; brtaken_ex = x.br; ld_ex = x.ld;
    wsel_ex = x.wsel; rs_id = x.rs; rt_id = x.rt;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic bit dmiss(input in_t x);
    return m_wait ? !x.dhit : ((x.dren || x.dwen) && !x.dhit);
  endfunction

  // Which single rule governs this cycle, by priority.
  function automatic logic [8:0] model_out(input in_t x);
    bit lu;
    lu = x.ld && (x.wsel != 0) && (x.wsel == x.rs || x.wsel == x.rt);
    if (m_halt)    return O_HLTD;
    if (m_drain)   return O_DRAIN;
    if (x.halt)    return O_HALT;
    if (dmiss(x))  return O_DSTL;
    if (x.br)      return O_BR;
    if (lu)        return O_LU;
    if (!x.ihit)   return O_IMISS;
    return O_DEF;
  endfunction

  task automatic model_adv(input in_t x, input bit pc);
    bit miss;
    miss = dmiss(x);
    if (!pc && !m_halt && !m_drain && m_cnt < 65535) m_cnt++;
    if (m_halt) ;
    else if (m_drain) begin m_drain = 0; m_halt = 1; end
    else if (x.halt) begin m_drain = 1; m_wait = 0; end
    else m_wait = miss;
  endtask

  task automatic step(input in_t x, input string nm);
    logic [8:0] e;
    @(negedge CLK);
    drive(x);
    #1;
    e = model_out(x);
    chk(nm, 32'({outs, halted, stall_cnt}), 32'({e, m_halt, m_cnt[15:0]}));
    @(posedge CLK);
    model_adv(x, e[8]);
  endtask

  // Assert reset between edges with x applied; outputs must already obey RUN rules.
  task automatic do_reset(input in_t x, input string nm);
    @(negedge CLK);
    drive(x);
    #2;
    nRST = 1'b0;
    m_wait = 0; m_drain = 0; m_halt = 0; m_cnt = 0;
    #1;
    chk(nm, 32'({outs, halted, stall_cnt}), 32'({model_out(x), 1'b0, 16'h0}));
    drive(mk(1,0,0,0,0,0,0,0,0,0));
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  in_t  IDLE;
  vec_t tbl[$];

  task automatic add(input string nm, input in_t x, input logic [8:0] e);
    vec_t v;
    v.name = nm; v.in = x; v.exp = e;
    tbl.push_back(v);
  endtask

  initial begin
    IDLE = mk(1,0,0,0,0,0,0,0,0,0);
    drive(IDLE);
    #12;
    nRST = 1'b1;

    // Single-cycle outcomes from a freshly reset pipeline.
    add("idle",          IDLE,                        O_DEF);
    add("imiss",         mk(0,0,0,0,0,0,0,0,0,0),     O_IMISS);
    add("lu_rt",         mk(1,0,0,0,0,0,1,8,3,8),     O_LU);
    add("lu_wsel0",      mk(1,0,0,0,0,0,1,0,0,0),     O_DEF);
    add("lu_rs",         mk(1,0,0,0,0,0,1,5,5,9),     O_LU);
    add("noload_match",  mk(1,0,0,0,0,0,0,5,5,5),     O_DEF);
    add("br_lu_imiss",   mk(0,0,0,0,0,1,1,8,3,8),     O_BR);
    add("dread_miss",    mk(1,0,1,0,0,0,0,0,0,0),     O_DSTL);
    add("dwrite_hit",    mk(1,1,0,1,0,0,0,0,0,0),     O_DEF);
    add("halt_over_all", mk(0,0,1,0,1,1,1,4,4,4),     O_HALT);
    add("dstall_over_br",mk(1,0,0,1,0,1,0,0,0,0),     O_DSTL);
    add("lu_imiss",      mk(0,0,0,0,0,0,1,7,0,7),     O_LU);
    foreach (tbl[i]) begin
      do_reset(IDLE, "reset_state");
      @(negedge CLK);
      drive(tbl[i].in);
      #1;
      chk(tbl[i].name, 32'(outs), 32'(tbl[i].exp));
    end

    // Quiet run after reset.
    do_reset(IDLE, "reset_quiet");
    repeat (5) step(IDLE, "quiet");
    chk("quiet_outs", 32'({outs, stall_cnt}), 32'({O_DEF, 16'h0}));

    // Three missed data reads, then the hit.
    do_reset(IDLE, "reset_dwait");
    repeat (3) step(mk(1,0,1,0,0,0,0,0,0,0), "dwait_miss");
    step(mk(1,1,1,0,0,0,0,0,0,0), "dwait_hit");
    chk("dwait_cnt", 32'(stall_cnt), 32'd3);
    step(mk(1,0,0,0,0,0,0,0,0,0), "after_dwait_run");

    // Branch beats load-use and fetch miss; counter does not move.
    do_reset(IDLE, "reset_br");
    step(mk(0,0,0,0,0,0,0,0,0,0), "pre_br_imiss");
    step(mk(0,0,0,0,0,1,1,8,8,8), "br_priority");
    chk("br_cnt_hold", 32'(stall_cnt), 32'd1);

    // HALT from DWAIT: one drain cycle, then sticky halted.
    do_reset(IDLE, "reset_halt");
    step(mk(1,0,1,0,0,0,0,0,0,0), "halt_pre_miss");
    step(mk(1,0,1,0,1,0,0,0,0,0), "halt_in_dwait");
    step(IDLE, "drain");
    for (int i = 0; i < 6; i++) begin
      step(mk(i[0], i[1], 0,0,0,0,0,0,0,0), "halted_toggle");
      chk("halted_sticky", 32'({halted, outs}), 32'({1'b1, O_HLTD}));
    end
    do_reset(IDLE, "reset_clears_halted");

    // Reset landing mid-DWAIT and mid-DRAIN.
    repeat (2) step(mk(1,0,1,0,0,0,0,0,0,0), "pre_rst_miss");
    do_reset(mk(0,0,0,0,0,0,0,0,0,0), "reset_mid_dwait");
    step(mk(1,0,0,0,1,0,0,0,0,0), "pre_rst_halt");
    do_reset(mk(0,0,0,0,0,0,0,0,0,0), "reset_mid_drain");
    step(IDLE, "post_drain_reset");

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      do_reset(rnd(), "reset_rand");
      for (int n = 0; n < 200; n++) step(rnd(), "rand");
    end

    // Saturation of the stall counter under sustained fetch misses.
    do_reset(IDLE, "reset_sat");
    @(negedge CLK);
    drive(mk(0,0,0,0,0,0,0,0,0,0));
    repeat (65534) @(posedge CLK);
    @(negedge CLK);
    chk("cnt_fffe", 32'(stall_cnt), 32'h0000FFFE);
    repeat (6) @(posedge CLK);
    @(negedge CLK);
    chk("cnt_saturate", 32'(stall_cnt), 32'h0000FFFF);
    do_reset(IDLE, "reset_after_sat");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
